// File: rtl/mem_wb_stage_pkg.sv
// Shared encodings and widths for the MEM/WB writeback stage.
// Holds the writeback-source and load-size/sign codes used by the stage and by decode.
package mem_wb_stage_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;

  // Writeback source select; 2'b11 is reserved and falls back to the ALU result.
  localparam logic [1:0] WB_SRC_ALU  = 2'b00;
  localparam logic [1:0] WB_SRC_MEM  = 2'b01;
  localparam logic [1:0] WB_SRC_LINK = 2'b10;

  // Load size/sign encodings.
  localparam logic [1:0] LD_WORD   = 2'b00;
  localparam logic [1:0] LD_HALF_S = 2'b01;
  localparam logic [1:0] LD_BYTE_S = 2'b10;
  localparam logic [1:0] LD_BYTE_U = 2'b11;

endpackage

// File: rtl/mem_wb_stage_reg_file.sv
// Register file, 2 async read ports with write-through bypass, 1 write port; r0 reads zero.
// Reads are zero-latency, writes land at the clock edge; there is no backpressure.
module mem_wb_stage_reg_file #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int NUM_REGS   = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_pend,
  input  logic                  wr_commit,
  input  logic [REG_ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0]     wr_dat,
  input  logic [REG_ADDR_W-1:0] rd_addr1,
  input  logic [REG_ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0]     rd_dat1,
  output logic [DATA_W-1:0]     rd_dat2
);

  logic [DATA_W-1:0] regs [NUM_REGS];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_commit && (wr_addr != '0)) begin
      regs[wr_addr] <= wr_dat;
    end
  end

  // Bypass follows the pending write, not the commit, so it stays visible during a stall.
  always_comb begin
    rd_dat1 = regs[rd_addr1];
    if (rd_addr1 == '0)                          rd_dat1 = '0;
    else if (wr_pend && (rd_addr1 == wr_addr))   rd_dat1 = wr_dat;

    rd_dat2 = regs[rd_addr2];
    if (rd_addr2 == '0)                          rd_dat2 = '0;
    else if (wr_pend && (rd_addr2 == wr_addr))   rd_dat2 = wr_dat;
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register, writeback select, load formatting, register file and retire counter.
// One register stage (commit one edge after capture); stall holds the slot, flush inserts a bubble.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int DATA_W     = mem_wb_stage_pkg::DATA_W,
  parameter int REG_ADDR_W = mem_wb_stage_pkg::REG_ADDR_W,
  parameter int NUM_REGS   = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  valid_in,
  input  logic [DATA_W-1:0]     pc_in,
  input  logic [DATA_W-1:0]     alu_result_in,
  input  logic [DATA_W-1:0]     mem_data_in,
  input  logic [REG_ADDR_W-1:0] write_reg_in,
  input  logic                  regwrite_in,
  input  logic [1:0]            memtoreg_in,
  input  logic [1:0]            decodeop_in,
  input  logic [REG_ADDR_W-1:0] read_reg1,
  input  logic [REG_ADDR_W-1:0] read_reg2,
  output logic [DATA_W-1:0]     read_data1,
  output logic [DATA_W-1:0]     read_data2,
  output logic [DATA_W-1:0]     wb_data,
  output logic [REG_ADDR_W-1:0] wb_reg,
  output logic                  wb_en,
  output logic [31:0]           retired
);

  typedef struct packed {
    logic                  valid;
    logic [DATA_W-1:0]     pc;
    logic [DATA_W-1:0]     alu;
    logic [DATA_W-1:0]     mem_data;
    logic [REG_ADDR_W-1:0] wreg;
    logic                  regwrite;
    logic [1:0]            memtoreg;
    logic [1:0]            decodeop;
  } memwb_t;

  memwb_t q;
  logic   fire;

  // Little-endian sub-word extraction; misaligned word/half accesses ignore the low offset bits.
  function automatic logic [DATA_W-1:0] fmt_load(input logic [DATA_W-1:0] w,
                                                 input logic [1:0]        off,
                                                 input logic [1:0]        op);
    logic [15:0] h;
    logic [7:0]  b;
    h = off[1] ? w[31:16] : w[15:0];
    b = w[{off, 3'b000} +: 8];
    case (op)
      LD_WORD:   fmt_load = w;
      LD_HALF_S: fmt_load = {{(DATA_W-16){h[15]}}, h};
      LD_BYTE_S: fmt_load = {{(DATA_W-8){b[7]}}, b};
      default:   fmt_load = {{(DATA_W-8){1'b0}}, b};
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (flush) begin
      q <= '0;
    end else if (!stall) begin
      q.valid    <= valid_in;
      q.pc       <= pc_in;
      q.alu      <= alu_result_in;
      q.mem_data <= mem_data_in;
      q.wreg     <= write_reg_in;
      q.regwrite <= regwrite_in;
      q.memtoreg <= memtoreg_in;
      q.decodeop <= decodeop_in;
    end
  end

  always_comb begin
    case (q.memtoreg)
      WB_SRC_MEM:  wb_data = fmt_load(q.mem_data, q.alu[1:0], q.decodeop);
      WB_SRC_LINK: wb_data = q.pc + DATA_W'(4);
      default:     wb_data = q.alu;
    endcase
  end

  assign wb_reg = q.wreg;
  assign wb_en  = q.valid & q.regwrite & (q.wreg != '0);
  assign fire   = q.valid & ~stall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      retired <= '0;
    else if (fire) retired <= retired + 32'd1;
  end

  mem_wb_stage_reg_file #(
    .DATA_W     (DATA_W),
    .REG_ADDR_W (REG_ADDR_W),
    .NUM_REGS   (NUM_REGS)
  ) u_reg_file (
    .clk       (clk),
    .rst       (rst),
    .wr_pend   (wb_en),
    .wr_commit (fire & wb_en),
    .wr_addr   (wb_reg),
    .wr_dat    (wb_data),
    .rd_addr1  (read_reg1),
    .rd_addr2  (read_reg2),
    .rd_dat1   (read_data1),
    .rd_dat2   (read_data2)
  );

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: reset, ALU/load/link writeback, r0, stall/flush, mid-run reset.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, flush, valid_in;
  logic [31:0] pc_in, alu_result_in, mem_data_in;
  logic [4:0]  write_reg_in;
  logic        regwrite_in;
  logic [1:0]  memtoreg_in, decodeop_in;
  logic [4:0]  read_reg1, read_reg2;
  logic [31:0] read_data1, read_data2, wb_data;
  logic [4:0]  wb_reg;
  logic        wb_en;
  logic [31:0] retired;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_ret = 0;

  always #5 clk = ~clk;

  mem_wb_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .valid_in(valid_in),
    .pc_in(pc_in), .alu_result_in(alu_result_in), .mem_data_in(mem_data_in),
    .write_reg_in(write_reg_in), .regwrite_in(regwrite_in),
    .memtoreg_in(memtoreg_in), .decodeop_in(decodeop_in),
    .read_reg1(read_reg1), .read_reg2(read_reg2),
    .read_data1(read_data1), .read_data2(read_data2),
    .wb_data(wb_data), .wb_reg(wb_reg), .wb_en(wb_en), .retired(retired)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] alu,
                       input logic [31:0] md, input logic [4:0] wr, input logic rw,
                       input logic [1:0] m2r, input logic [1:0] dop);
    valid_in = v; pc_in = pc; alu_result_in = alu; mem_data_in = md;
    write_reg_in = wr; regwrite_in = rw; memtoreg_in = m2r; decodeop_in = dop;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 2'b00, 2'b00);
  endtask

  task automatic test_reset();
    rst = 1'b0; stall = 1'b0; flush = 1'b0; idle();
    read_reg1 = 5'd5; read_reg2 = 5'd0;
    step(); step();
    total++; if (retired !== 32'd0) begin bad++; $display("FAIL reset_retired got=%h exp=%h", retired, 32'd0); end
    total++; if (wb_en !== 1'b0) begin bad++; $display("FAIL reset_wb_en got=%b exp=0", wb_en); end
    total++; if (wb_data !== 32'd0) begin bad++; $display("FAIL reset_wb_data got=%h exp=0", wb_data); end
    rst = 1'b1;
    step();
    total++; if (read_data1 !== 32'd0) begin bad++; $display("FAIL reset_r5 got=%h exp=0", read_data1); end
    total++; if (retired !== 32'd0) begin bad++; $display("FAIL reset_retired_after got=%h exp=0", retired); end
    exp_ret = 0;
  endtask

  task automatic test_alu_write();
    drive(1'b1, 32'h0, 32'h0000_1234, 32'h0, 5'd8, 1'b1, 2'b00, 2'b00);
    step();
    idle(); read_reg1 = 5'd8; #1;
    total++; if (wb_en !== 1'b1) begin bad++; $display("FAIL alu_wb_en got=%b exp=1", wb_en); end
    total++; if (wb_reg !== 5'd8) begin bad++; $display("FAIL alu_wb_reg got=%0d exp=8", wb_reg); end
    total++; if (read_data1 !== 32'h0000_1234) begin bad++; $display("FAIL alu_bypass got=%h exp=%h", read_data1, 32'h1234); end
    step(); exp_ret++;
    total++; if (wb_en !== 1'b0) begin bad++; $display("FAIL alu_bubble_wb_en got=%b exp=0", wb_en); end
    total++; if (read_data1 !== 32'h0000_1234) begin bad++; $display("FAIL alu_regfile got=%h exp=%h", read_data1, 32'h1234); end
    total++; if (retired !== exp_ret) begin bad++; $display("FAIL alu_retired got=%0d exp=%0d", retired, exp_ret); end
  endtask

  task automatic test_loads();
    logic [1:0]  dops [4];
    logic [1:0]  offs [4];
    logic [31:0] exps [4];
    dops[0] = 2'b10; offs[0] = 2'd3; exps[0] = 32'hFFFF_FF80;
    dops[1] = 2'b11; offs[1] = 2'd1; exps[1] = 32'h0000_007F;
    dops[2] = 2'b01; offs[2] = 2'd2; exps[2] = 32'hFFFF_80FF;
    dops[3] = 2'b00; offs[3] = 2'd0; exps[3] = 32'h80FF_7F01;
    read_reg2 = 5'd10;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h0, {30'h40, offs[i]}, 32'h80FF_7F01, 5'd10, 1'b1, 2'b01, dops[i]);
      step();
      idle(); #1;
      total++; if (wb_data !== exps[i]) begin bad++; $display("FAIL load%0d_wb_data got=%h exp=%h", i, wb_data, exps[i]); end
      step(); exp_ret++;
      total++; if (read_data2 !== exps[i]) begin bad++; $display("FAIL load%0d_regfile got=%h exp=%h", i, read_data2, exps[i]); end
    end
    total++; if (retired !== exp_ret) begin bad++; $display("FAIL load_retired got=%0d exp=%0d", retired, exp_ret); end
  endtask

  task automatic test_link_r0();
    drive(1'b1, 32'h0040_0010, 32'h0, 32'h0, 5'd31, 1'b1, 2'b10, 2'b00);
    step();
    idle(); #1;
    total++; if (wb_data !== 32'h0040_0014) begin bad++; $display("FAIL link_wb_data got=%h exp=%h", wb_data, 32'h0040_0014); end
    step(); exp_ret++;
    drive(1'b1, 32'h0, 32'h0000_0055, 32'h0, 5'd0, 1'b1, 2'b00, 2'b00);
    step();
    idle(); read_reg1 = 5'd0; #1;
    total++; if (wb_en !== 1'b0) begin bad++; $display("FAIL r0_wb_en got=%b exp=0", wb_en); end
    total++; if (read_data1 !== 32'd0) begin bad++; $display("FAIL r0_bypass got=%h exp=0", read_data1); end
    step(); exp_ret++;
    total++; if (read_data1 !== 32'd0) begin bad++; $display("FAIL r0_regfile got=%h exp=0", read_data1); end
    total++; if (retired !== exp_ret) begin bad++; $display("FAIL r0_retired got=%0d exp=%0d", retired, exp_ret); end
  endtask

  task automatic test_stall();
    drive(1'b1, 32'h0, 32'h0000_A5A5, 32'h0, 5'd12, 1'b1, 2'b00, 2'b00);
    step();
    idle(); stall = 1'b1; read_reg1 = 5'd12;
    for (int k = 0; k < 3; k++) begin
      step();
      total++; if (wb_en !== 1'b1) begin bad++; $display("FAIL stall%0d_wb_en got=%b exp=1", k, wb_en); end
      total++; if (read_data1 !== 32'h0000_A5A5) begin bad++; $display("FAIL stall%0d_bypass got=%h exp=%h", k, read_data1, 32'hA5A5); end
      total++; if (retired !== exp_ret) begin bad++; $display("FAIL stall%0d_retired got=%0d exp=%0d", k, retired, exp_ret); end
    end
    stall = 1'b0;
    step(); exp_ret++;
    total++; if (retired !== exp_ret) begin bad++; $display("FAIL stall_release_retired got=%0d exp=%0d", retired, exp_ret); end
    total++; if (wb_en !== 1'b0) begin bad++; $display("FAIL stall_release_wb_en got=%b exp=0", wb_en); end
    total++; if (read_data1 !== 32'h0000_A5A5) begin bad++; $display("FAIL stall_regfile got=%h exp=%h", read_data1, 32'hA5A5); end
    step();
    total++; if (retired !== exp_ret) begin bad++; $display("FAIL stall_single_retire got=%0d exp=%0d", retired, exp_ret); end
  endtask

  task automatic test_stall_flush();
    drive(1'b1, 32'h0, 32'h0000_0077, 32'h0, 5'd13, 1'b1, 2'b00, 2'b00);
    step();
    drive(1'b1, 32'h0, 32'h0000_0099, 32'h0, 5'd14, 1'b1, 2'b00, 2'b00);
    stall = 1'b1; flush = 1'b1; read_reg1 = 5'd13; read_reg2 = 5'd14;
    step();
    stall = 1'b0; flush = 1'b0; idle(); #1;
    total++; if (wb_en !== 1'b0) begin bad++; $display("FAIL sf_wb_en got=%b exp=0", wb_en); end
    total++; if (retired !== exp_ret) begin bad++; $display("FAIL sf_retired got=%0d exp=%0d", retired, exp_ret); end
    total++; if (read_data1 !== 32'd0) begin bad++; $display("FAIL sf_r13 got=%h exp=0", read_data1); end
    step();
    total++; if (retired !== exp_ret) begin bad++; $display("FAIL sf_no_retire got=%0d exp=%0d", retired, exp_ret); end
    total++; if (read_data2 !== 32'd0) begin bad++; $display("FAIL sf_r14 got=%h exp=0", read_data2); end
  endtask

  task automatic test_mid_reset();
    drive(1'b1, 32'h0, 32'hDEAD_BEEF, 32'h0, 5'd9, 1'b1, 2'b00, 2'b00);
    step();
    idle(); read_reg1 = 5'd9; read_reg2 = 5'd8; #1;
    total++; if (read_data1 !== 32'hDEAD_BEEF) begin bad++; $display("FAIL mr_bypass got=%h exp=%h", read_data1, 32'hDEAD_BEEF); end
    rst = 1'b0; #1;
    total++; if (wb_en !== 1'b0) begin bad++; $display("FAIL mr_wb_en got=%b exp=0", wb_en); end
    total++; if (retired !== 32'd0) begin bad++; $display("FAIL mr_retired got=%0d exp=0", retired); end
    step();
    rst = 1'b1;
    step(); exp_ret = 0;
    total++; if (read_data1 !== 32'd0) begin bad++; $display("FAIL mr_r9 got=%h exp=0", read_data1); end
    total++; if (read_data2 !== 32'd0) begin bad++; $display("FAIL mr_r8 got=%h exp=0", read_data2); end
    total++; if (retired !== exp_ret) begin bad++; $display("FAIL mr_retired_after got=%0d exp=%0d", retired, exp_ret); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_alu_write();
    test_loads();
    test_link_r0();
    test_stall();
    test_stall_flush();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
Final pipeline stage, directly downstream of the memory phase. It holds the MEM/WB pipeline register and selects the writeback value from the ALU result, the load data or the link address. It formats sub-word loads and owns the 32x32 register file, which has write-through bypass on both read ports. It also keeps a retired-instruction counter used by the testbench.

Parameters:
DATA_W, 32, datapath width in bits
REG_ADDR_W, 5, register index width
NUM_REGS, 32, register-file depth; register 0 always reads zero

Ports:
clk  in  1  pipeline clock, rising edge
rst  in  1  asynchronous, active-low reset
stall  in  1  hold MEM/WB contents and suppress commit
flush  in  1  replace the incoming instruction with a bubble
valid_in  in  1  EX/MEM slot holds a real instruction
pc_in  in  32  PC+4 from EX/MEM
alu_result_in  in  32  ALU result / effective address from EX/MEM
mem_data_in  in  32  raw aligned word from the memory phase
write_reg_in  in  5  destination register from EX/MEM
regwrite_in  in  1  instruction writes a register
memtoreg_in  in  2  writeback source select
decodeop_in  in  2  load size/sign: 00 word, 01 half signed, 10 byte signed, 11 byte unsigned
read_reg1  in  5  decode read address A
read_reg2  in  5  decode read address B
read_data1  out  32  register data A, with bypass
read_data2  out  32  register data B, with bypass
wb_data  out  32  selected writeback value, for forwarding
wb_reg  out  5  writeback destination
wb_en  out  1  a valid register write is pending in WB
retired  out  32  count of committed instructions

Behaviour:
- Reset (rst=0, asynchronous):
  - all MEM/WB fields clear, valid_q=0, retired=0, every register-file entry=0.
  - Outputs: wb_en=0, wb_reg=0, wb_data=0; read_data1/2 return 0.
- MEM/WB capture, on each rising edge when rst=1:
  - flush=1: valid_q<=0, other fields don't-care. flush wins over stall.
  - else stall=1: all fields hold.
  - else: all *_in fields captured; valid_q<=valid_in.
- Writeback select (combinational from MEM/WB):
  - memtoreg 00: alu_q.
  - 01: formatted load.
  - 10: pc_q+4, the link address, giving PC+8 semantics.
  - 11: alu_q, reserved.
- Load formatting (little-endian, offset = alu_q[1:0]):
  - word: mem_data unchanged.
  - half: offset[1] selects bits [31:16] or [15:0], sign-extended.
  - byte: offset selects one of four bytes, sign- or zero-extended per decodeop.
  - Misaligned word or half: the low address bits are ignored and the access is treated as aligned; no trap.
- Status outputs:
  - wb_en = valid_q & regwrite_q & (wreg_q != 0).
  - wb_reg = wreg_q; wb_data = the selected value.
- Commit: fire = valid_q & ~stall.
  - At the rising edge where fire & wb_en, regfile[wreg_q] <= wb_data.
  - retired increments by 1 on every fire, including non-writing instructions; it wraps modulo 2^32.
- Read ports (combinational):
  - address 0 returns 0.
  - else if wb_en and address == wb_reg, return wb_data (same-cycle write-through).
  - else return the register-file contents.
- Latency: an instruction entering at edge N is visible on wb_* during cycle N..N+1 and is committed at edge N+1, assuming no stall.
- Stall held for k cycles: a single commit and a single retire increment once the stall releases; bypass stays active throughout.
- Simultaneous stall and flush: the bubble is inserted; the instruction currently held is not committed that edge (fire=0).
- Reset mid-operation: any pending write is discarded; nothing is partially committed.

Decomposition:
- Shared package:
  - memtoreg encodings: WB_SRC_ALU, WB_SRC_MEM, WB_SRC_LINK.
  - decodeop encodings: LD_WORD, LD_HALF_S, LD_BYTE_S, LD_BYTE_U.
  - DATA_W and REG_ADDR_W constants.
- Sub-module reg_file: 2 read ports, 1 write port, asynchronous active-low clear, r0 hardwired to zero, internal write-through bypass.
- The load formatter stays an inline function.

Test Plan:
- Reset: hold rst=0, then release → retired=0, wb_en=0, read_data1 for r5 = 0.
- ALU write: valid=1, regwrite=1, wreg=8, memtoreg=00, alu=0x0000_1234 → wb_en=1 the next cycle, read_reg1=8 bypasses 0x1234, register file holds 0x1234 after the following edge, retired=1.
- Loads with mem_data=0x80FF_7F01:
  - lb, alu[1:0]=3 → 0xFFFF_FF80.
  - lbu, alu[1:0]=1 → 0x0000_007F.
  - lh, alu[1:0]=2 → 0xFFFF_80FF.
  - lw → 0x80FF_7F01.
- Link and r0:
  - memtoreg=10, pc_in=0x0040_0010 → wb_data=0x0040_0014.
  - Write to r0 → wb_en=0, r0 still reads 0, retired still increments.
- Stall/flush:
  - Stall 3 cycles with a write pending → exactly one commit and retired +1 after release.
  - flush and stall together → next slot is a bubble, wb_en=0, no retire.
- Mid-operation reset: drop rst during a pending write to r9 (0xDEAD_BEEF) → r9 reads 0, retired=0.
